// File: rtl/hazard_controller_pkg.sv
// Shared control-bundle type passed from the decoder through the hazard controller into ID/EX.
package hazard_controller_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } controls_s;

endpackage

// File: rtl/hazard_controller.sv
// Pipeline-front hazard controller: forwards the decoded control bundle or injects bubbles for
// load-use stalls and taken-branch flushes, and counts injected bubbles.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned FLUSH_CYCLES   = 2,
  parameter int unsigned REG_W          = 5
) (
  input  logic             clk,
  input  logic             n_reset,
  input  controls_s        decoded_ctrl_i,
  input  logic             decoded_valid_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             rs_used_i,
  input  logic             rt_used_i,
  input  logic             id_ex_mem_read_i,
  input  logic [REG_W-1:0] id_ex_dest_i,
  input  logic             branch_taken_i,
  output controls_s        newControl_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic [7:0]       bubble_count_o
);

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  localparam logic [3:0] StallExtra = 4'(LOAD_USE_STALL - 1);
  localparam logic [3:0] FlushExtra = 4'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] remain_q, remain_d;
  logic [7:0] count_q, count_d;
  logic       hazard;

  assign hazard = decoded_valid_i && id_ex_mem_read_i && (id_ex_dest_i != '0) &&
                  ((rs_used_i && (rs_i == id_ex_dest_i)) || (rt_used_i && (rt_i == id_ex_dest_i)));

  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    newControl_o = '0;
    stall_o      = 1'b0;
    flush_o      = 1'b0;
    if (branch_taken_i) begin
      flush_o = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d  = StFlush;
        remain_d = FlushExtra;
      end else begin
        state_d  = StRun;
        remain_d = '0;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (hazard) begin
            stall_o = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              state_d  = StStall;
              remain_d = StallExtra;
            end
          end else if (decoded_valid_i) begin
            newControl_o = decoded_ctrl_i;
          end
        end
        StStall: begin
          stall_o  = 1'b1;
          remain_d = remain_q - 4'd1;
          if (remain_q == 4'd1) state_d = StRun;
        end
        StFlush: begin
          flush_o  = 1'b1;
          remain_d = remain_q - 4'd1;
          if (remain_q == 4'd1) state_d = StRun;
        end
        default: begin
          state_d  = StRun;
          remain_d = '0;
        end
      endcase
    end
    // Outputs are forced quiet for the whole time reset is held, whatever the inputs do.
    if (!n_reset) begin
      newControl_o = '0;
      stall_o      = 1'b0;
      flush_o      = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if ((stall_o || flush_o) && (count_q != 8'hff)) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= StRun;
      remain_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      count_q  <= count_d;
    end
  end

  assign bubble_count_o = count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a reference model queues expected outputs per cycle and
// an independent monitor compares them against the DUT.
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  localparam int unsigned Lus   = 2;
  localparam int unsigned Flush = 2;
  localparam int unsigned RegW  = 5;

  logic            clk = 1'b0;
  logic            n_reset = 1'b0;
  controls_s       decoded_ctrl;
  logic            decoded_valid;
  logic [RegW-1:0] rs, rt, id_ex_dest;
  logic            rs_used, rt_used, id_ex_mem_read, branch_taken;
  controls_s       new_control;
  logic            stall, flush;
  logic [7:0]      bubble_count;

  hazard_controller #(
    .LOAD_USE_STALL(Lus),
    .FLUSH_CYCLES  (Flush),
    .REG_W         (RegW)
  ) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .decoded_ctrl_i  (decoded_ctrl),
    .decoded_valid_i (decoded_valid),
    .rs_i            (rs),
    .rt_i            (rt),
    .rs_used_i       (rs_used),
    .rt_used_i       (rt_used),
    .id_ex_mem_read_i(id_ex_mem_read),
    .id_ex_dest_i    (id_ex_dest),
    .branch_taken_i  (branch_taken),
    .newControl_o    (new_control),
    .stall_o         (stall),
    .flush_o         (flush),
    .bubble_count_o  (bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    controls_s  ctrl;
    logic       stall;
    logic       flush;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: bubbles still owed, tracked as plain integers.
  int stall_left = 0;
  int flush_left = 0;
  int bubbles    = 0;

  function automatic void check(string name, int unsigned got, int unsigned want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endfunction

  // Monitor: outputs are valid every cycle; sample mid-cycle, away from the posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("newControl", 32'(new_control), 32'(e.ctrl));
        check("stall", 32'(stall), 32'(e.stall));
        check("flush", 32'(flush), 32'(e.flush));
        check("bubble_count", 32'(bubble_count), 32'(e.cnt));
        check("stall_and_flush", 32'(stall & flush), 32'd0);
      end
    end
  end

  task automatic cycle(input logic rst_n, input logic valid, input controls_s ctrl,
                       input int r_s, input int r_t, input logic su, input logic tu,
                       input logic mr, input int dst, input logic br);
    exp_t e;
    bit   haz;
    @(posedge clk);
    #1;
    n_reset        = rst_n;
    decoded_valid  = valid;
    decoded_ctrl   = ctrl;
    rs             = RegW'(r_s);
    rt             = RegW'(r_t);
    rs_used        = su;
    rt_used        = tu;
    id_ex_mem_read = mr;
    id_ex_dest     = RegW'(dst);
    branch_taken   = br;

    e.ctrl  = '0;
    e.stall = 1'b0;
    e.flush = 1'b0;
    e.cnt   = 8'(bubbles);
    haz = valid && mr && (dst != 0) && ((su && r_s == dst) || (tu && r_t == dst));
    if (!rst_n) begin
      e.cnt      = 8'd0;
      stall_left = 0;
      flush_left = 0;
      bubbles    = 0;
    end else begin
      if (br) begin
        e.flush    = 1'b1;
        flush_left = int'(Flush) - 1;
        stall_left = 0;
      end else if (flush_left > 0) begin
        e.flush = 1'b1;
        flush_left--;
      end else if (stall_left > 0) begin
        e.stall = 1'b1;
        stall_left--;
      end else if (haz) begin
        e.stall    = 1'b1;
        stall_left = int'(Lus) - 1;
      end else if (valid) begin
        e.ctrl = ctrl;
      end
      if ((e.stall || e.flush) && bubbles < 255) bubbles++;
    end
    exp_q.push_back(e);
  endtask

  controls_s c;

  initial begin
    c = controls_s'(12'h9a5);
    // Reset held with a valid instruction and a taken branch present.
    repeat (3) cycle(1'b0, 1'b1, c, 7, 7, 1'b1, 1'b1, 1'b1, 7, 1'b1);
    // No hazard: source 3 vs load destination 4.
    cycle(1'b1, 1'b1, c, 3, 0, 1'b1, 1'b0, 1'b1, 4, 1'b0);
    // Load-use on rt: two stall cycles, then the bundle passes.
    c = controls_s'(12'h3c1);
    cycle(1'b1, 1'b1, c, 1, 7, 1'b0, 1'b1, 1'b1, 7, 1'b0);
    cycle(1'b1, 1'b1, c, 1, 7, 1'b0, 1'b1, 1'b1, 7, 1'b0);
    cycle(1'b1, 1'b1, c, 1, 7, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    // Destination $0 never stalls; an unused source never stalls.
    cycle(1'b1, 1'b1, c, 0, 0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    cycle(1'b1, 1'b1, c, 9, 2, 1'b0, 1'b1, 1'b1, 9, 1'b0);
    // Invalid IF/ID gives an uncounted bubble.
    cycle(1'b1, 1'b0, c, 9, 9, 1'b1, 1'b1, 1'b1, 9, 1'b0);
    // Branch in the same cycle as a load-use hazard wins.
    cycle(1'b1, 1'b1, c, 5, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1);
    cycle(1'b1, 1'b1, c, 5, 0, 1'b1, 1'b0, 1'b1, 5, 1'b0);
    cycle(1'b1, 1'b1, c, 5, 0, 1'b1, 1'b0, 1'b0, 5, 1'b0);
    // Saturate the counter with back-to-back flushes, then reset mid-flush.
    repeat (300) cycle(1'b1, 1'b1, c, 1, 2, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    cycle(1'b0, 1'b1, c, 1, 2, 1'b1, 1'b1, 1'b0, 3, 1'b0);
    cycle(1'b1, 1'b1, c, 1, 2, 1'b1, 1'b1, 1'b0, 3, 1'b0);
    // Randomised traffic with small register indices so hazards are frequent.
    for (int i = 0; i < 2000; i++) begin
      c = controls_s'($urandom_range(0, 4095));
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 4) != 0), c,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 11) == 0));
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
